// File: rtl/data_mem_store_buffer.sv
// Posted-store data memory: stores queue in a small FIFO and drain into a word RAM when no load is active.
// Build option MEM_INIT_CLEAR_EN zero-fills the RAM after reset before any access is served.
module data_mem_store_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [31:0]              Addressmem,
    input  logic [31:0]              WriteDataMem,
    input  logic                     memWrite,
    input  logic                     memRead,
    output logic [31:0]              ReadData,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int MEM_WORDS = 1 << ADDR_BITS;

    logic [31:0]          mem [MEM_WORDS];
    logic [ADDR_BITS-1:0] buf_idx  [DEPTH];
    logic [31:0]          buf_data [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;

    logic [ADDR_BITS-1:0] idx;
    logic                 full, clearing, push, pop;
    logic                 fwd_hit;
    logic [31:0]          fwd_data;
    logic [PW-1:0]        pos;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [31:0]          mem_wdata;
    logic                 unused_addr;

    assign idx         = Addressmem[ADDR_BITS+1:2];
    assign unused_addr = ^{Addressmem[31:ADDR_BITS+2], Addressmem[1:0]};

`ifdef MEM_INIT_CLEAR_EN
    // state   | meaning
    // S_CLEAR | zero-filling RAM one word per cycle; stores held, loads read 0
    // S_IDLE  | normal buffered operation
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] clr_idx;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        clearing  = 1'b0;
        case (state)
            S_CLEAR: begin
                clearing = 1'b1;
                if (&clr_idx)
                    state_nxt = S_IDLE;
            end
            default: ;
        endcase
    end
`else
    assign clearing = 1'b0;
`endif

    assign full      = (count == CW'(DEPTH));
    assign stall     = memWrite && (full || clearing);
    assign push      = memWrite && !full && !clearing;
    assign pop       = (count != '0) && !memRead && !clearing;
    assign buf_count = count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            buf_idx[wr_ptr]  <= idx;
            buf_data[wr_ptr] <= WriteDataMem;
        end
    end

    // Scan oldest to youngest so the last match (closest to wr_ptr-1) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        pos      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            pos = wr_ptr - PW'(i + 1);
            if (valid[pos] && (buf_idx[pos] == idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[pos];
            end
        end
    end

    always_comb begin
        mem_we    = pop;
        mem_waddr = buf_idx[rd_ptr];
        mem_wdata = buf_data[rd_ptr];
`ifdef MEM_INIT_CLEAR_EN
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        ReadData = '0;
        if (memRead && !clearing)
            ReadData = fwd_hit ? fwd_data : mem[idx];
    end

endmodule

// File: doc/data_mem_store_buffer.md
Name: data_mem_store_buffer

Overview:
- Data-memory stage directly downstream of the TopLevel MIPS core.
- Consumes the core's store port (Addressmem, WriteDataMem, memWrite) and serves its loads.
- Stores are posted into a small FIFO and drained into a word-addressed RAM on cycles when no load uses the RAM port.
- Loads see their own pending stores through youngest-match forwarding, so buffering is invisible to program order.

Parameters:
- DEPTH, 4, store-buffer entries; power of two, minimum 2.
- ADDR_BITS, 8, RAM word-index width; MEM_WORDS = 2**ADDR_BITS = 256.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addressmem  input  32  byte address from core; word index = Addressmem[ADDR_BITS+1:2].
- WriteDataMem  input  32  store data.
- memWrite  input  1  store request.
- memRead  input  1  load request.
- ReadData  output  32  load data, combinational.
- stall  output  1  store not accepted this cycle; core holds its request.
- buf_count  output  clog2(DEPTH)+1  number of occupied buffer entries.

Behaviour:
- Reset, async on the reset posedge: wr_ptr=0, rd_ptr=0, count=0, all valid bits 0, so stall=0 and buf_count=0. RAM contents are not reset unless the Optional Feature is compiled in.
- Word index:
  - Addressmem[1:0] is ignored; accesses are word-aligned.
  - Bits above ADDR_BITS+1 are ignored, so addresses alias modulo 1 KiB.
- Push:
  - Condition: memWrite=1 and count<DEPTH.
  - Effect: {index, WriteDataMem} is written at wr_ptr; wr_ptr advances modulo DEPTH.
  - Latency: the entry is visible to forwarding from the next cycle.
- Full:
  - stall = memWrite && (count==DEPTH), combinational; the store is dropped that cycle.
  - A pop in the same cycle does not clear stall; the store is accepted the following cycle.
- Drain (pop):
  - Condition: count>0 and memRead=0.
  - Effect: the head entry is written to RAM[index]; rd_ptr advances modulo DEPTH.
  - Latency: one entry per cycle; loads have priority over drain.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Load:
  - ReadData = youngest valid buffer entry whose index matches, else RAM[index].
  - "Youngest" means the entry closest to wr_ptr-1, searching backward.
  - ReadData=0 when memRead=0.
  - memRead and memWrite in the same cycle: the load does not see the same-cycle store; it forwards from older state only.
- Pointer wrap: pointers wrap modulo DEPTH; count is the authoritative full/empty indicator.
- Reset mid-operation: pending buffer entries are discarded and never reach RAM. This is intended behaviour.
- memWrite with X/Z data: the data is stored as is; no checking.

Optional Feature:
- Macro: MEM_INIT_CLEAR_EN.
- With the macro:
  - After reset deasserts, an FSM moves CLEAR→IDLE.
  - CLEAR writes 0 to RAM[clr_idx] for clr_idx = 0..MEM_WORDS-1, one word per cycle, so it lasts MEM_WORDS cycles.
  - During CLEAR: stall = memWrite (all stores held), ReadData=0, and no drain occurs.
  - IDLE is entered the cycle after the write to clr_idx = MEM_WORDS-1.
  - Reset during CLEAR restarts the clear at index 0.
- Without the macro: there is no FSM; the block is IDLE immediately after reset, and RAM powers up undefined (X in simulation).

Test Plan:
- Store then load:
  - Stimulus: memWrite with Addressmem=0x10, data 0xDEADBEEF; next cycle memRead at 0x10.
  - Required: ReadData=0xDEADBEEF (forwarded); buf_count=1 on that load cycle.
  - Then: after one idle cycle, buf_count=0 and a load at 0x10 still returns 0xDEADBEEF (from RAM).
- Youngest-match forwarding:
  - Stimulus: hold memRead=1 while storing 0x11111111 then 0x22222222 to 0x20.
  - Required: a load at 0x20 returns 0x22222222 with buf_count=2; after 2 drain cycles RAM[8]=0x22222222.
- Full and stall:
  - Stimulus: with memRead=1 continuously, issue 5 consecutive stores to 0x0,0x4,0x8,0xC,0x10.
  - Required: stall=0 for the first 4; stall=1 on the 5th; buf_count=4.
  - Then: drop memRead; the held 5th store is accepted 1 cycle later than the first pop.
- Aliasing and misalignment:
  - Stimulus: store 0xA5A5A5A5 at Addressmem=0x00000403.
  - Required: a load at 0x00000000 returns 0xA5A5A5A5.
- Reset mid-drain:
  - Stimulus: fill 3 entries under memRead=1; pulse reset asynchronously (not aligned to CLK).
  - Required: buf_count=0 and stall=0 immediately; the targeted RAM words keep their old values.
- MEM_INIT_CLEAR_EN:
  - Stimulus: release reset.
  - Required: stall=1 on any store for 256 cycles; afterwards a load at any address returns 0; the first store is accepted in cycle 257.
